fifo18_gmii_tx: RTL

Read-side consumer of the 18-bit dual-clock frame FIFO: pops framed 18-bit words from the FIFO's read port and serializes them onto a GMII-style 8-bit transmit interface. It runs entirely in the FIFO read clock domain and sits between the FIFO and the PHY TX pins. It enforces a minimum inter-frame gap and aborts cleanly on FIFO underrun.

---
 rtl/fifo18_pkg.sv | 31 +++
 rtl/fifo18_gmii_tx_if.sv | 19 +
 rtl/fifo18_gmii_tx.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fifo18_pkg.sv
// Shared constants and state encoding for the 18-bit FIFO to GMII transmitter.
// FIFO18_TX_PREAMBLE_EN adds the preamble state and its constants.
package fifo18_pkg;

  localparam int unsigned LAST_BIT    = 17;
  localparam int unsigned LOVALID_BIT = 16;

`ifdef FIFO18_TX_PREAMBLE_EN
  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [7:0] PRE_LEN  = 8'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_LOAD,
    S_DATA,
    S_DRAIN,
    S_GAP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DATA,
    S_DRAIN,
    S_GAP
  } state_t;
`endif

endpackage

// File: rtl/fifo18_gmii_tx_if.sv
// FIFO read port plus GMII transmit pins; master is the transmitter side.
interface fifo18_gmii_tx_if;
  logic [17:0] Q;
  logic        Empty;
  logic        RdEn;
  logic        TxEn;
  logic        TxEr;
  logic [7:0]  TxD;

  modport master (
    input  Q, Empty,
    output RdEn, TxEn, TxEr, TxD
  );

  modport slave (
    output Q, Empty,
    input  RdEn, TxEn, TxEr, TxD
  );
endinterface

// File: rtl/fifo18_gmii_tx.sv
// Pops framed 18-bit words from the FIFO and serialises them onto GMII TX.
// Optional preamble/SFD prefix is enabled by FIFO18_TX_PREAMBLE_EN.
module fifo18_gmii_tx
  import fifo18_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = 12
) (
  input  logic                    RdClock,
  input  logic                    Reset,
  fifo18_gmii_tx_if.master        bus,
  output logic [15:0]             UnderrunCnt
);

  // The IDLE cycle (and LOAD without preamble) are already idle on the wire,
  // so GAP only has to cover the remainder of the inter-frame gap.
`ifdef FIFO18_TX_PREAMBLE_EN
  localparam int unsigned START_OVH = 1;
`else
  localparam int unsigned START_OVH = 2;
`endif
  localparam logic [7:0] GAP_LOAD =
    (IFG_CYCLES > START_OVH) ? 8'(IFG_CYCLES - START_OVH) : 8'd0;
  localparam state_t END_STATE = (GAP_LOAD != 8'd0) ? S_GAP : S_IDLE;

  state_t      state;
  logic        lo_phase;
  logic        pend;
  logic [17:0] word;
  logic [7:0]  cnt;
  logic        tx_en;
  logic        tx_er;
  logic [7:0]  tx_d;
  logic [15:0] urun_cnt;
  logic        rd_en;
  logic        word_last;
  logic        word_lov;

  assign word_last = word[LAST_BIT];
  assign word_lov  = word[LOVALID_BIT];

  always_comb begin
    rd_en = 1'b0;
    if (!Reset && !bus.Empty) begin
      case (state)
        S_IDLE:  rd_en = 1'b1;
        S_DATA:  rd_en = !lo_phase && !word_last;
        S_DRAIN: rd_en = !pend;
        default: rd_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge RdClock) begin
    if (Reset) begin
      state    <= S_IDLE;
      lo_phase <= 1'b0;
      pend     <= 1'b0;
      word     <= '0;
      cnt      <= '0;
      tx_en    <= 1'b0;
      tx_er    <= 1'b0;
      tx_d     <= '0;
      urun_cnt <= '0;
    end else begin
      tx_en <= 1'b0;
      tx_er <= 1'b0;
      tx_d  <= '0;
      case (state)
        S_IDLE: begin
          if (!bus.Empty) begin
`ifdef FIFO18_TX_PREAMBLE_EN
            state <= S_PRE;
            pend  <= 1'b1;
            cnt   <= PRE_LEN - 8'd1;
            tx_en <= 1'b1;
            tx_d  <= PRE_BYTE;
`else
            state <= S_LOAD;
`endif
          end
        end
`ifdef FIFO18_TX_PREAMBLE_EN
        S_PRE: begin
          tx_en <= 1'b1;
          if (pend) begin
            word <= bus.Q;
            pend <= 1'b0;
          end
          if (cnt == 8'd0) begin
            tx_d     <= word[15:8];
            lo_phase <= 1'b0;
            state    <= S_DATA;
          end else begin
            tx_d <= (cnt == 8'd1) ? SFD_BYTE : PRE_BYTE;
            cnt  <= cnt - 8'd1;
          end
        end
`endif
        S_LOAD: begin
          word     <= bus.Q;
          tx_en    <= 1'b1;
          tx_d     <= bus.Q[15:8];
          lo_phase <= 1'b0;
          state    <= S_DATA;
        end
        // lo_phase=0: high byte on the wire, low byte being registered and
        // the next word prefetched; lo_phase=1: low byte on the wire.
        S_DATA: begin
          if (!lo_phase) begin
            lo_phase <= 1'b1;
            pend     <= rd_en;
            if (word_last && !word_lov) begin
              state <= END_STATE;
              cnt   <= GAP_LOAD;
            end else begin
              tx_en <= 1'b1;
              tx_d  <= word[7:0];
            end
          end else begin
            lo_phase <= 1'b0;
            if (word_last) begin
              state <= END_STATE;
              cnt   <= GAP_LOAD;
            end else if (pend) begin
              word  <= bus.Q;
              pend  <= 1'b0;
              tx_en <= 1'b1;
              tx_d  <= bus.Q[15:8];
            end else begin
              tx_en <= 1'b1;
              tx_er <= 1'b1;
              if (urun_cnt != '1) urun_cnt <= urun_cnt + 16'd1;
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (pend) begin
            word <= bus.Q;
            pend <= 1'b0;
            if (bus.Q[LAST_BIT]) begin
              state <= END_STATE;
              cnt   <= GAP_LOAD;
            end
          end else begin
            pend <= rd_en;
          end
        end
        S_GAP: begin
          if (cnt <= 8'd1) state <= S_IDLE;
          else             cnt   <= cnt - 8'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.RdEn    = rd_en;
  assign bus.TxEn    = tx_en;
  assign bus.TxEr    = tx_er;
  assign bus.TxD     = tx_d;
  assign UnderrunCnt = urun_cnt;

endmodule
